// File: rtl/checkin_dispatcher.sv
// -----------------------------------------------------------------------------
// checkin_dispatcher
//   Queues student arrivals (ID plus timestamp) in a small FIFO and dispatches
//   checkIn, delete (serve) and list commands to a pharmacy memory.
//   Only one command is in flight at a time.
//
//   IDLE arbitration uses fixed priority: serve, then checkIn, then list.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   arrive_valid/_id      : arrival offer (5-bit student ID)
//   arrive_ready          : FIFO has room (fifo_count < FIFO_DEPTH)
//   serve_req, list_req   : one-cycle request pulses, latched until serviced
//   mem_mode              : 0 list, 1 idle, 2 checkIn, 3 delete
//   mem_studentID         : ID carried by a checkIn command, 0 otherwise
//   mem_checkInTime       : timestamp carried by a checkIn command, 0 otherwise
//   mem_listBusy/ready    : pharmacy memory status
//   occupancy             : entries held in pharmacy memory
//   fifo_count            : entries waiting in the arrival FIFO
//   serve_empty/list_done : one-cycle status pulses
//
// Parameters
//   FIFO_DEPTH : power of two, 2..4 (fifo_count is 3 bits)
//   TICK_DIV   : clock cycles per timestamp tick
//   MEM_CAP    : pharmacy memory capacity (at most 15)
//
// Build option
//   TIME_SATURATE_EN : when defined, the timestamp holds at 255 instead of
//                      wrapping, so the memory's time ordering stays valid.
// -----------------------------------------------------------------------------
module checkin_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 4,
    parameter int MEM_CAP    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arrive_valid,
    input  logic [4:0] arrive_id,
    output logic       arrive_ready,
    input  logic       serve_req,
    input  logic       list_req,
    output logic [1:0] mem_mode,
    output logic [4:0] mem_studentID,
    output logic [7:0] mem_checkInTime,
    input  logic       mem_listBusy,
    input  logic       mem_ready,
    output logic [3:0] occupancy,
    output logic [2:0] fifo_count,
    output logic       serve_empty,
    output logic       list_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] MODE_LIST  = 2'd0;
    localparam logic [1:0] MODE_IDLE  = 2'd1;
    localparam logic [1:0] MODE_CHKIN = 2'd2;
    localparam logic [1:0] MODE_DEL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE           = 2'd0,
        S_ISSUE          = 2'd1,
        S_LIST_WAIT_BUSY = 2'd2,
        S_LIST_WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       time_q, time_d;
    logic [4:0]       fifo_id_q [FIFO_DEPTH];
    logic [7:0]       fifo_tm_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q, count_d;
    logic [3:0]       occ_q, occ_d;
    logic             spend_q, spend_d, lpend_q, lpend_d;
    logic [1:0]       mode_q, mode_d;
    logic [4:0]       sid_q, sid_d;
    logic [7:0]       stime_q, stime_d;
    logic             se_q, se_d, ld_q, ld_d;
    logic             push_s, pop_s, spend_clr_s, lpend_clr_s;

    // No same-cycle bypass: readiness depends only on the registered count.
    assign arrive_ready    = (count_q < 3'(FIFO_DEPTH));
    assign push_s          = arrive_valid & arrive_ready;
    assign fifo_count      = count_q;
    assign occupancy       = occ_q;
    assign mem_mode        = mode_q;
    assign mem_studentID   = sid_q;
    assign mem_checkInTime = stime_q;
    assign serve_empty     = se_q;
    assign list_done       = ld_q;

    // Timestamp prescaler and tick counter next state.
    always_comb begin
        div_d  = div_q;
        time_d = time_q;
        if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_d = {DIV_W{1'b0}};
`ifdef TIME_SATURATE_EN
            if (time_q != 8'hFF) begin
                time_d = time_q + 8'd1;
            end else begin
                time_d = time_q;
            end
`else
            time_d = time_q + 8'd1;
`endif
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Timestamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= {DIV_W{1'b0}};
            time_q <= 8'd0;
        end else begin
            div_q  <= div_d;
            time_q <= time_d;
        end
    end

    // Arrival FIFO count; a push and pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
    end

    // Arrival FIFO storage and pointers; pointers wrap as FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= 3'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_id_q[i] <= 5'd0;
                fifo_tm_q[i] <= 8'd0;
            end
        end else begin
            if (push_s) begin
                fifo_id_q[wr_ptr_q] <= arrive_id;
                fifo_tm_q[wr_ptr_q] <= time_q;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Dispatcher FSM: arbitration, command formation and occupancy tracking.
    // Command outputs are computed for the next state so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        pop_s       = 1'b0;
        spend_clr_s = 1'b0;
        lpend_clr_s = 1'b0;
        mode_d      = MODE_IDLE;
        sid_d       = 5'd0;
        stime_d     = 8'd0;
        se_d        = 1'b0;
        ld_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (spend_q) begin
                    spend_clr_s = 1'b1;
                    if (occ_q != 4'd0) begin
                        state_d = S_ISSUE;
                        mode_d  = MODE_DEL;
                        occ_d   = occ_q - 4'd1;
                    end else begin
                        se_d = 1'b1;
                    end
                end else if ((count_q != 3'd0) && (occ_q < 4'(MEM_CAP))) begin
                    pop_s   = 1'b1;
                    state_d = S_ISSUE;
                    mode_d  = MODE_CHKIN;
                    sid_d   = fifo_id_q[rd_ptr_q];
                    stime_d = fifo_tm_q[rd_ptr_q];
                    occ_d   = occ_q + 4'd1;
                end else if (lpend_q) begin
                    if (occ_q != 4'd0) begin
                        state_d = S_LIST_WAIT_BUSY;
                        mode_d  = MODE_LIST;
                    end else begin
                        lpend_clr_s = 1'b1;
                        ld_d        = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            S_LIST_WAIT_BUSY: begin
                mode_d = MODE_LIST;
                if (mem_listBusy) begin
                    state_d = S_LIST_WAIT_DONE;
                end else begin
                    state_d = S_LIST_WAIT_BUSY;
                end
            end
            S_LIST_WAIT_DONE: begin
                if (!mem_listBusy && mem_ready) begin
                    state_d     = S_IDLE;
                    lpend_clr_s = 1'b1;
                    ld_d        = 1'b1;
                end else begin
                    mode_d = MODE_LIST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending flags: a clear in the servicing cycle wins over a new request.
    always_comb begin
        spend_d = spend_clr_s ? 1'b0 : (spend_q | serve_req);
        lpend_d = lpend_clr_s ? 1'b0 : (lpend_q | list_req);
    end

    // FSM state, flags, occupancy and registered memory command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            occ_q   <= 4'd0;
            spend_q <= 1'b0;
            lpend_q <= 1'b0;
            mode_q  <= MODE_IDLE;
            sid_q   <= 5'd0;
            stime_q <= 8'd0;
            se_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            spend_q <= spend_d;
            lpend_q <= lpend_d;
            mode_q  <= mode_d;
            sid_q   <= sid_d;
            stime_q <= stime_d;
            se_q    <= se_d;
            ld_q    <= ld_d;
        end
    end

endmodule

// File: tb/tb_checkin_dispatcher.sv
// Testbench for checkin_dispatcher: per-cycle comparison against a queue-based
// reference model, plus directed scenarios with constant expectations.
module tb_checkin_dispatcher;

    localparam int FIFO_DEPTH = 4;
    localparam int TICK_DIV   = 4;
    localparam int MEM_CAP    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arrive_valid = 1'b0;
    logic [4:0] arrive_id = 5'd0;
    logic       arrive_ready;
    logic       serve_req = 1'b0;
    logic       list_req = 1'b0;
    logic [1:0] mem_mode;
    logic [4:0] mem_studentID;
    logic [7:0] mem_checkInTime;
    logic       mem_listBusy = 1'b0;
    logic       mem_ready = 1'b1;
    logic [3:0] occupancy;
    logic [2:0] fifo_count;
    logic       serve_empty;
    logic       list_done;

    checkin_dispatcher #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TICK_DIV  (TICK_DIV),
        .MEM_CAP   (MEM_CAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arrive_valid   (arrive_valid),
        .arrive_id      (arrive_id),
        .arrive_ready   (arrive_ready),
        .serve_req      (serve_req),
        .list_req       (list_req),
        .mem_mode       (mem_mode),
        .mem_studentID  (mem_studentID),
        .mem_checkInTime(mem_checkInTime),
        .mem_listBusy   (mem_listBusy),
        .mem_ready      (mem_ready),
        .occupancy      (occupancy),
        .fifo_count     (fifo_count),
        .serve_empty    (serve_empty),
        .list_done      (list_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] id;
        logic [7:0] tm;
    } entry_t;

    entry_t m_fifo[$];
    int     m_time, m_div, m_occ, m_mode, m_id, m_tm, m_stage;
    bit     m_spend, m_lpend, m_se, m_ld;

    task automatic model_reset();
        m_fifo.delete();
        m_time = 0; m_div = 0; m_occ = 0;
        m_mode = 1; m_id = 0; m_tm = 0; m_stage = 0;
        m_spend = 0; m_lpend = 0; m_se = 0; m_ld = 0;
    endtask

    // Advance the model by one clock edge given the inputs presented at that edge.
    task automatic model_step(input bit av, input logic [4:0] aid, input bit sr, input bit lr,
                              input bit busy, input bit rdy);
        int     n_mode = 1;
        int     n_id = 0;
        int     n_tm = 0;
        bit     n_se = 0;
        bit     n_ld = 0;
        bit     clr_s = 0;
        bit     clr_l = 0;
        bit     acc;
        entry_t head;
        entry_t e;
        acc = av && (m_fifo.size() < FIFO_DEPTH);
        if (m_mode == 1) begin
            if (m_spend) begin
                clr_s = 1;
                if (m_occ > 0) begin n_mode = 3; m_occ--; end
                else n_se = 1;
            end else if (m_fifo.size() > 0 && m_occ < MEM_CAP) begin
                head = m_fifo.pop_front();
                n_mode = 2; n_id = int'(head.id); n_tm = int'(head.tm); m_occ++;
            end else if (m_lpend) begin
                if (m_occ > 0) begin n_mode = 0; m_stage = 1; end
                else begin clr_l = 1; n_ld = 1; end
            end
        end else if (m_mode == 0) begin
            if (m_stage == 1) begin
                n_mode = 0;
                if (busy) m_stage = 2;
            end else if (!busy && rdy) begin
                m_stage = 0; clr_l = 1; n_ld = 1;
            end else begin
                n_mode = 0;
            end
        end
        if (acc) begin
            e.id = aid; e.tm = 8'(m_time);
            m_fifo.push_back(e);
        end
        m_spend = clr_s ? 1'b0 : (m_spend | sr);
        m_lpend = clr_l ? 1'b0 : (m_lpend | lr);
        m_div++;
        if (m_div == TICK_DIV) begin
            m_div = 0;
`ifdef TIME_SATURATE_EN
            if (m_time < 255) m_time++;
`else
            m_time = (m_time + 1) % 256;
`endif
        end
        m_mode = n_mode; m_id = n_id; m_tm = n_tm; m_se = n_se; m_ld = n_ld;
    endtask

    // ---------------- memory model, logging, per-cycle driver ----------------
    int          lcnt = 0, blen = 1, fixed_blen = 0;
    int          se_seen = 0, ld_seen = 0, active_seen = 0;
    int          prev_mode = 1;
    logic [14:0] log_q[$];

    function automatic logic [14:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        else return 15'h7FFF;
    endfunction

    // Called at a falling edge: compare, then present inputs for the next rising edge.
    task automatic cycle(input bit av, input logic [4:0] aid, input bit sr, input bit lr);
        logic exp_rdy;
        exp_rdy = (m_fifo.size() < FIFO_DEPTH);
        check_val("cmd", {mem_mode, mem_studentID, mem_checkInTime},
                  {2'(m_mode), 5'(m_id), 8'(m_tm)});
        check_val("status", {occupancy, fifo_count, arrive_ready},
                  {4'(m_occ), 3'(m_fifo.size()), exp_rdy});
        check_val("pulse", {serve_empty, list_done}, {m_se, m_ld});
        if (serve_empty) se_seen++;
        if (list_done) ld_seen++;
        if (mem_mode != 2'd1) active_seen++;
        if (mem_mode == 2'd2 || mem_mode == 2'd3 || (mem_mode == 2'd0 && prev_mode != 0))
            log_q.push_back({mem_mode, mem_studentID, mem_checkInTime});
        prev_mode = int'(mem_mode);
        if (mem_mode == 2'd0) lcnt++;
        else lcnt = 0;
        if (lcnt == 1) blen = (fixed_blen != 0) ? fixed_blen : int'($urandom_range(1, 6));
        mem_listBusy = (lcnt >= 2) && (lcnt < 2 + blen);
        mem_ready    = !mem_listBusy && ($urandom_range(0, 3) != 0);
        arrive_valid = av; arrive_id = aid; serve_req = sr; list_req = lr;
        model_step(av, aid, sr, lr, mem_listBusy, mem_ready);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks that outputs respond without a clock edge.
    task automatic do_reset();
        arrive_valid = 1'b0; serve_req = 1'b0; list_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_mode", mem_mode, 2'd1);
        check_val("rst_cmd", {mem_studentID, mem_checkInTime}, 13'd0);
        check_val("rst_occ", occupancy, 4'd0);
        check_val("rst_fifo", fifo_count, 3'd0);
        check_val("rst_ready", arrive_ready, 1'b1);
        check_val("rst_pulse", {serve_empty, list_done}, 2'b00);
        model_reset();
        lcnt = 0; prev_mode = 1; mem_listBusy = 1'b0; mem_ready = 1'b1;
        log_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          acc_n;
        logic [14:0] e;
        @(negedge clk);
        do_reset();

        // IDs 3,7,1 pushed at timestamps 0,1,2
        cycle(1'b1, 5'd3, 1'b0, 1'b0); idle(3);
        cycle(1'b1, 5'd7, 1'b0, 1'b0); idle(3);
        cycle(1'b1, 5'd1, 1'b0, 1'b0); idle(10);
        check_val("r38_n", log_q.size(), 3);
        check_val("r38_e0", log_at(0), {2'd2, 5'd3, 8'd0});
        check_val("r38_e1", log_at(1), {2'd2, 5'd7, 8'd1});
        check_val("r38_e2", log_at(2), {2'd2, 5'd1, 8'd2});
        check_val("r38_occ", occupancy, 4'd3);

        // 12 arrivals against a capacity of 10
        do_reset();
        acc_n = 0;
        for (int n = 0; n < 200 && acc_n < 12; n++) begin
            if (m_fifo.size() < FIFO_DEPTH) begin
                cycle(1'b1, 5'(acc_n + 1), 1'b0, 1'b0);
                acc_n++;
            end else begin
                cycle(1'b1, 5'(acc_n + 1), 1'b0, 1'b0);
            end
        end
        idle(30);
        check_val("cap_accepted", acc_n, 12);
        check_val("cap_occ", occupancy, 4'd10);
        check_val("cap_fifo", fifo_count, 3'd2);
        check_val("cap_nchk", log_q.size(), 10);
        log_q.delete();
        cycle(1'b0, 5'd0, 1'b1, 1'b0); idle(8);
        e = log_at(0);
        check_val("cap_del", e[14:13], 2'd3);
        e = log_at(1);
        check_val("cap_next_chk", e[14:8], {2'd2, 5'd11});
        check_val("cap_fifo2", fifo_count, 3'd1);

        // serve with nothing stored
        do_reset();
        se_seen = 0; active_seen = 0;
        cycle(1'b0, 5'd0, 1'b1, 1'b0); idle(6);
        check_val("empty_pulses", se_seen, 1);
        check_val("empty_nocmd", active_seen, 0);

        // serve, checkIn and list pending together
        cycle(1'b1, 5'd5, 1'b0, 1'b0); idle(6);
        log_q.delete();
        cycle(1'b1, 5'd9, 1'b1, 1'b1); idle(30);
        e = log_at(0); check_val("prio_0", e[14:13], 2'd3);
        e = log_at(1); check_val("prio_1", e[14:8], {2'd2, 5'd9});
        e = log_at(2); check_val("prio_2", e[14:13], 2'd0);

        // list with four entries and a four-cycle busy window
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'(20 + i), 1'b0, 1'b0); idle(3);
        end
        idle(6);
        check_val("list_occ", occupancy, 4'd4);
        fixed_blen = 4; ld_seen = 0;
        cycle(1'b0, 5'd0, 1'b0, 1'b1); idle(25);
        check_val("list_done_n", ld_seen, 1);

        // reset while waiting for the list to finish, with arrivals queued
        cycle(1'b0, 5'd0, 1'b0, 1'b1);
        for (int n = 0; n < 30 && m_stage != 2; n++) cycle(1'b1, 5'(n), 1'b0, 1'b0);
        check_val("pre_rst_list", mem_mode, 2'd0);
        do_reset();
        fixed_blen = 0;

        // randomized traffic
        for (int n = 0; n < 1500; n++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        idle(40);

        // timestamp after 1100 cycles
        do_reset();
        idle(1100);
        cycle(1'b1, 5'd21, 1'b0, 1'b0); idle(4);
`ifdef TIME_SATURATE_EN
        check_val("time_1100", log_at(0), {2'd2, 5'd21, 8'd255});
`else
        check_val("time_1100", log_at(0), {2'd2, 5'd21, 8'd19});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
